// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its cache.
package if_stage_pkg;

    localparam int          ICACHE_INDEX_W_DEF = 7;
    localparam logic [31:0] RESET_PC_DEF       = 32'h0000_0000;

    typedef logic [31:0] inst_addr_bus_t;
    typedef logic [31:0] inst_bus_t;

    typedef enum logic {
        IF_IDLE  = 1'b0,
        IF_FETCH = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup,
// synchronous fill, valid bits cleared by synchronous reset.
module if_stage_icache
    import if_stage_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_word,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  logic [31:0] wr_data
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    logic [LINES-1:0]   line_valid;
    logic [TAG_W-1:0]   line_tag  [LINES];
    logic [31:0]        line_data [LINES];
    logic [INDEX_W-1:0] rd_idx;
    logic [INDEX_W-1:0] wr_idx;

    assign rd_idx  = rd_word[INDEX_W-1:0];
    assign wr_idx  = wr_word[INDEX_W-1:0];
    assign hit     = line_valid[rd_idx] && (line_tag[rd_idx] == rd_word[29:INDEX_W]);
    assign rd_data = line_data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (wr_en) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_tag[wr_idx]  <= wr_word[29:INDEX_W];
            line_data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, icache lookup, byte-serial miss fill and the
// registered {pc, inst, valid} presented to decode.
//
//   state    | meaning
//   IF_IDLE  | looking up pc; a hit presents it, a miss starts a fill
//   IF_FETCH | collecting four bytes of the word at pc from memory
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          ICACHE_INDEX_W = ICACHE_INDEX_W_DEF,
    parameter logic [31:0] RESET_PC       = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_valid_in,
    input  logic [7:0]  mem_byte_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid_out
);

    if_state_t      state, state_n;
    inst_addr_bus_t pc, pc_n;
    logic [1:0]     byte_cnt, byte_cnt_n;
    logic [23:0]    buffer, buffer_n;
    inst_addr_bus_t pc_out_n, mem_addr_n;
    inst_bus_t      inst_out_n, line;
    logic           inst_valid_n, mem_req_n;
    logic           hit, last_byte, cache_we;
    logic           unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target_in[1:0];

    // The fourth byte fills the line even when a redirect discards the fetch.
    assign last_byte = (state == IF_FETCH) && mem_valid_in && (byte_cnt == 2'd3);
    assign cache_we  = last_byte && !rst;

    if_stage_icache #(
        .INDEX_W (ICACHE_INDEX_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc[31:2]),
        .hit     (hit),
        .rd_data (line),
        .wr_en   (cache_we),
        .wr_word (pc[31:2]),
        .wr_data ({mem_byte_in, buffer})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (branch_taken_in) begin
            state_n = IF_IDLE;
        end else begin
            case (state)
                IF_IDLE:  if (!hit)     state_n = IF_FETCH;
                IF_FETCH: if (last_byte) state_n = IF_IDLE;
                default:                state_n = IF_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_n         = pc;
        byte_cnt_n   = byte_cnt;
        buffer_n     = buffer;
        pc_out_n     = pc_out;
        inst_out_n   = inst_out;
        inst_valid_n = inst_valid_out;
        mem_req_n    = mem_req_out;
        mem_addr_n   = mem_addr_out;
        if (branch_taken_in) begin
            pc_n         = {branch_target_in[31:2], 2'b00};
            inst_valid_n = 1'b0;
            mem_req_n    = 1'b0;
            byte_cnt_n   = 2'd0;
        end else begin
            case (state)
                IF_IDLE: begin
                    if (hit) begin
                        if (!stall_in) begin
                            pc_out_n     = pc;
                            inst_out_n   = line;
                            inst_valid_n = 1'b1;
                            pc_n         = pc + 32'd4;
                        end
                    end else begin
                        // A miss starts filling even under stall so the line is ready on release.
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                        byte_cnt_n = 2'd0;
                        if (!stall_in) inst_valid_n = 1'b0;
                    end
                end
                IF_FETCH: begin
                    if (!stall_in) inst_valid_n = 1'b0;
                    if (mem_valid_in) begin
                        case (byte_cnt)
                            2'd0:    buffer_n[7:0]   = mem_byte_in;
                            2'd1:    buffer_n[15:8]  = mem_byte_in;
                            2'd2:    buffer_n[23:16] = mem_byte_in;
                            default: ;
                        endcase
                        byte_cnt_n = byte_cnt + 2'd1;
                        mem_addr_n = mem_addr_out + 32'd1;
                        if (byte_cnt == 2'd3) mem_req_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            byte_cnt       <= 2'd0;
            buffer         <= '0;
            pc_out         <= '0;
            inst_out       <= '0;
            inst_valid_out <= 1'b0;
            mem_req_out    <= 1'b0;
            mem_addr_out   <= '0;
        end else begin
            pc             <= pc_n;
            byte_cnt       <= byte_cnt_n;
            buffer         <= buffer_n;
            pc_out         <= pc_out_n;
            inst_out       <= inst_out_n;
            inst_valid_out <= inst_valid_n;
            mem_req_out    <= mem_req_n;
            mem_addr_out   <= mem_addr_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch scenarios plus a randomized run against
// a fetch-level reference model (program order, cache residency, byte fills).
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_valid_in;
    logic [7:0]  mem_byte_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:4095];
    bit         random_mode = 0;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .mem_req_out      (mem_req_out),
        .mem_addr_out     (mem_addr_out),
        .mem_valid_in     (mem_valid_in),
        .mem_byte_in      (mem_byte_in),
        .pc_out           (pc_out),
        .inst_out         (inst_out),
        .inst_valid_out   (inst_valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
    endfunction

    // Byte-wide memory: answers shortly after each rising edge, valid for the next edge.
    initial begin
        int lat_cnt;
        int cur_lat;
        lat_cnt      = 0;
        cur_lat      = 0;
        mem_valid_in = 1'b0;
        mem_byte_in  = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req_out && lat_cnt >= cur_lat) begin
                mem_valid_in = 1'b1;
                mem_byte_in  = mem[mem_addr_out[11:0]];
                lat_cnt      = 0;
                cur_lat      = random_mode ? int'($urandom_range(0, 2)) : 0;
            end else begin
                mem_valid_in = 1'b0;
                mem_byte_in  = 8'($urandom);
                lat_cnt      = mem_req_out ? lat_cnt + 1 : 0;
            end
        end
    end

    task automatic wait_present(input logic [31:0] a, output bit ok);
        int n;
        n = 0;
        while (!(inst_valid_out === 1'b1 && pc_out === a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 300);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pc_out !== 32'h0 || inst_out !== 32'h0 || inst_valid_out !== 1'b0 ||
            mem_req_out !== 1'b0 || mem_addr_out !== 32'h0)
            begin errors++; $display("FAIL reset: pc_out=%h inst=%h valid=%b req=%b addr=%h, expected all zero",
                                     pc_out, inst_out, inst_valid_out, mem_req_out, mem_addr_out); end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_out !== 1'b1 || mem_addr_out !== 32'(i))
                begin errors++; $display("FAIL cold_addr[%0d]: req=%b addr=%h, expected req=1 addr=%h",
                                         i, mem_req_out, mem_addr_out, i); end
        end
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b0 || inst_valid_out !== 1'b0)
            begin errors++; $display("FAIL cold_fill_done: req=%b valid=%b, expected 0 0", mem_req_out, inst_valid_out); end
        @(negedge clk);
        checks++;
        if (inst_valid_out !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h00a00513)
            begin errors++; $display("FAIL cold_present: valid=%b pc=%h inst=%h, expected 1 00000000 00a00513",
                                     inst_valid_out, pc_out, inst_out); end
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h4)
            begin errors++; $display("FAIL cold_next_fetch: req=%b addr=%h, expected 1 00000004", mem_req_out, mem_addr_out); end
    endtask

    task automatic test_warm_loop();
        bit ok;
        wait_present(32'hC, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL warm_fill: pc 0000000c not presented, pc_out=%h valid=%b", pc_out, inst_valid_out); end
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h0;
        @(negedge clk);
        branch_taken_in = 1'b0;
        checks++;
        if (inst_valid_out !== 1'b0 || mem_req_out !== 1'b0)
            begin errors++; $display("FAIL warm_redirect: valid=%b req=%b, expected 0 0", inst_valid_out, mem_req_out); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid_out !== 1'b1 || pc_out !== 32'(4 * k) || inst_out !== word_at(32'(4 * k)) || mem_req_out !== 1'b0)
                begin errors++; $display("FAIL warm_hit[%0d]: valid=%b pc=%h inst=%h req=%b, expected 1 %h %h 0",
                                         k, inst_valid_out, pc_out, inst_out, mem_req_out, 4 * k, word_at(32'(4 * k))); end
        end
    endtask

    task automatic test_stall();
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h0;
        @(negedge clk);
        branch_taken_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (inst_valid_out !== 1'b1 || pc_out !== 32'h8)
            begin errors++; $display("FAIL stall_setup: valid=%b pc=%h, expected 1 00000008", inst_valid_out, pc_out); end
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid_out !== 1'b1 || pc_out !== 32'h8 || inst_out !== word_at(32'h8))
                begin errors++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h, expected 1 00000008 %h",
                                         k, inst_valid_out, pc_out, inst_out, word_at(32'h8)); end
        end
        stall_in = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid_out !== 1'b1 || pc_out !== 32'hC || inst_out !== word_at(32'hC))
            begin errors++; $display("FAIL stall_release: valid=%b pc=%h inst=%h, expected 1 0000000c %h",
                                     inst_valid_out, pc_out, inst_out, word_at(32'hC)); end
    endtask

    task automatic test_redirect_mid_miss();
        bit ok;
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h40;
        @(negedge clk);
        branch_taken_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h40 + 32'(i))
                begin errors++; $display("FAIL midmiss_addr[%0d]: req=%b addr=%h, expected 1 %h",
                                         i, mem_req_out, mem_addr_out, 32'h40 + 32'(i)); end
        end
        // Third byte arrives with the redirect and must be dropped.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h100;
        @(negedge clk);
        branch_taken_in = 1'b0;
        checks++;
        if (mem_req_out !== 1'b0 || inst_valid_out !== 1'b0)
            begin errors++; $display("FAIL midmiss_abort: req=%b valid=%b, expected 0 0", mem_req_out, inst_valid_out); end
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h100)
            begin errors++; $display("FAIL midmiss_target: req=%b addr=%h, expected 1 00000100", mem_req_out, mem_addr_out); end
        wait_present(32'h100, ok);
        checks++;
        if (!ok || inst_out !== word_at(32'h100))
            begin errors++; $display("FAIL midmiss_present: ok=%b inst=%h, expected 1 %h", ok, inst_out, word_at(32'h100)); end
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h40;
        @(negedge clk);
        branch_taken_in = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h40 || inst_valid_out !== 1'b0)
            begin errors++; $display("FAIL midmiss_not_filled: req=%b addr=%h valid=%b, expected 1 00000040 0",
                                     mem_req_out, mem_addr_out, inst_valid_out); end
        wait_present(32'h40, ok);
        checks++;
        if (!ok || inst_out !== word_at(32'h40))
            begin errors++; $display("FAIL midmiss_refill: ok=%b inst=%h, expected 1 %h", ok, inst_out, word_at(32'h40)); end
    endtask

    task automatic test_redirect_stall_last_byte();
        bit ok;
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h80;
        @(negedge clk);
        branch_taken_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h80 + 32'(i))
                begin errors++; $display("FAIL last_addr[%0d]: req=%b addr=%h, expected 1 %h",
                                         i, mem_req_out, mem_addr_out, 32'h80 + 32'(i)); end
        end
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h182;
        stall_in         = 1'b1;
        @(negedge clk);
        branch_taken_in = 1'b0;
        stall_in        = 1'b0;
        checks++;
        if (mem_req_out !== 1'b0 || inst_valid_out !== 1'b0)
            begin errors++; $display("FAIL last_redirect: req=%b valid=%b, expected 0 0", mem_req_out, inst_valid_out); end
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h180)
            begin errors++; $display("FAIL last_target: req=%b addr=%h, expected 1 00000180", mem_req_out, mem_addr_out); end
        wait_present(32'h180, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL last_present: pc 00000180 not presented, pc_out=%h", pc_out); end
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h80;
        @(negedge clk);
        branch_taken_in = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid_out !== 1'b1 || pc_out !== 32'h80 || inst_out !== word_at(32'h80) || mem_req_out !== 1'b0)
            begin errors++; $display("FAIL last_line_written: valid=%b pc=%h inst=%h req=%b, expected 1 00000080 %h 0",
                                     inst_valid_out, pc_out, inst_out, mem_req_out, word_at(32'h80)); end
    endtask

    task automatic test_reset_mid_fetch();
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h2C0;
        @(negedge clk);
        branch_taken_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h2C1)
            begin errors++; $display("FAIL rstmid_setup: req=%b addr=%h, expected 1 000002c1", mem_req_out, mem_addr_out); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_out !== 32'h0 || inst_out !== 32'h0 || inst_valid_out !== 1'b0 ||
            mem_req_out !== 1'b0 || mem_addr_out !== 32'h0)
            begin errors++; $display("FAIL rstmid_zero: pc=%h inst=%h valid=%b req=%b addr=%h, expected all zero",
                                     pc_out, inst_out, inst_valid_out, mem_req_out, mem_addr_out); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0 || inst_valid_out !== 1'b0)
            begin errors++; $display("FAIL rstmid_cache_cleared: req=%b addr=%h valid=%b, expected 1 00000000 0",
                                     mem_req_out, mem_addr_out, inst_valid_out); end
    endtask

    // Reference: instructions appear in program order from the redirect point;
    // resident words appear without memory traffic, others after a 4-byte fill.
    task automatic test_random();
        logic [31:0] line_pc [128];
        bit          line_ok [128];
        logic [31:0] m_pc, m_fpc, m_pc_out, m_inst, tgt;
        bit          m_valid, m_fetching, s, b, mv, res;
        int          m_cnt;
        int          presented;
        for (int i = 0; i < 128; i++) begin line_ok[i] = 0; line_pc[i] = 0; end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        random_mode = 1;
        m_pc = 0; m_fpc = 0; m_pc_out = 0; m_inst = 0;
        m_valid = 0; m_fetching = 0; m_cnt = 0; presented = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            s   = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 24) == 0);
            tgt = {21'd0, 11'($urandom)};
            stall_in         = s;
            branch_taken_in  = b;
            branch_target_in = tgt;
            mv  = mem_valid_in;
            res = line_ok[m_pc[8:2]] && line_pc[m_pc[8:2]] == m_pc;
            @(negedge clk);
            if (b) begin
                if (m_fetching && mv && m_cnt == 3) begin
                    line_ok[m_fpc[8:2]] = 1; line_pc[m_fpc[8:2]] = m_fpc;
                end
                m_pc = {tgt[31:2], 2'b00}; m_valid = 0; m_fetching = 0; m_cnt = 0;
            end else if (!m_fetching) begin
                if (res) begin
                    if (!s) begin
                        m_pc_out = m_pc; m_inst = word_at(m_pc); m_valid = 1;
                        m_pc = m_pc + 32'd4; presented++;
                    end
                end else begin
                    m_fetching = 1; m_fpc = m_pc; m_cnt = 0;
                    if (!s) m_valid = 0;
                end
            end else begin
                if (!s) m_valid = 0;
                if (mv) begin
                    if (m_cnt == 3) begin
                        line_ok[m_fpc[8:2]] = 1; line_pc[m_fpc[8:2]] = m_fpc;
                        m_fetching = 0; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            checks++;
            if (inst_valid_out !== m_valid)
                begin errors++; $display("FAIL rnd_valid cyc=%0d: got %b, expected %b", cyc, inst_valid_out, m_valid); end
            checks++;
            if (pc_out !== m_pc_out || inst_out !== m_inst)
                begin errors++; $display("FAIL rnd_present cyc=%0d: pc=%h inst=%h, expected %h %h",
                                         cyc, pc_out, inst_out, m_pc_out, m_inst); end
            checks++;
            if (mem_req_out !== m_fetching)
                begin errors++; $display("FAIL rnd_req cyc=%0d: got %b, expected %b", cyc, mem_req_out, m_fetching); end
            if (m_fetching) begin
                checks++;
                if (mem_addr_out !== m_fpc + 32'(m_cnt))
                    begin errors++; $display("FAIL rnd_addr cyc=%0d: got %h, expected %h", cyc, mem_addr_out, m_fpc + 32'(m_cnt)); end
            end
        end
        stall_in        = 1'b0;
        branch_taken_in = 1'b0;
        random_mode     = 0;
        checks++;
        if (presented < 50)
            begin errors++; $display("FAIL rnd_progress: only %0d instructions presented", presented); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'ha0; mem[3] = 8'h00;
        rst              = 1'b1;
        stall_in         = 1'b0;
        branch_taken_in  = 1'b0;
        branch_target_in = 32'h0;
        test_reset();
        test_cold_miss();
        test_warm_loop();
        test_stall();
        test_redirect_mid_miss();
        test_redirect_stall_last_byte();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Sits directly upstream of the decode stage.
- Holds the PC and looks it up in a small direct-mapped instruction cache.
- On a miss, assembles the 32-bit instruction from four byte reads through the byte-wide memory controller.
- Presents a registered {pc, inst, valid} triple to the IF/ID boundary; honours pipeline stall and EX branch redirect.

Parameters:
- ICACHE_INDEX_W, 7, log2 of cache line count (128 one-word lines).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_in  in  1  pipeline stall from ctrl (ID load-use stall or downstream stall); hold IF/ID outputs.
- branch_taken_in  in  1  redirect request from EX; one-cycle pulse.
- branch_target_in  in  32  redirect target PC, word aligned.
- mem_req_out  out  1  byte read request to memory controller, level.
- mem_addr_out  out  32  byte address of the current request.
- mem_valid_in  in  1  one-cycle pulse: mem_byte_in holds data for mem_addr_out.
- mem_byte_in  in  8  returned byte.
- pc_out  out  32  PC of the presented instruction.
- inst_out  out  32  presented instruction.
- inst_valid_out  out  1  pc_out/inst_out are a valid instruction for ID.

Behaviour:
- Reset:
  - pc <= RESET_PC; state <= IDLE; byte_cnt <= 0.
  - All cache valid bits cleared.
  - pc_out, inst_out <= 0; inst_valid_out <= 0; mem_req_out <= 0; mem_addr_out <= 0.
  - rst asserted mid-fetch aborts immediately; any pending mem_valid_in is ignored.
- Cache lookup:
  - index = pc[ICACHE_INDEX_W+1:2]; tag = pc[31:ICACHE_INDEX_W+2].
  - Read is combinational; write is synchronous.
- State IDLE, not stalled:
  - Hit: next edge sets inst_out <= line, pc_out <= pc, inst_valid_out <= 1, pc <= pc+4. Back-to-back hits give one instruction per cycle.
  - Miss: go to FETCH; mem_req_out <= 1; mem_addr_out <= pc; byte_cnt <= 0; inst_valid_out <= 0.
- State IDLE, stalled:
  - pc_out, inst_out, inst_valid_out hold.
  - pc does not advance.
  - On a miss at pc, the fetch is still started so it can proceed under the stall.
- State FETCH:
  - mem_req_out stays high; mem_addr_out = pc + byte_cnt and is stable until mem_valid_in.
  - Each mem_valid_in: buffer[8*byte_cnt +: 8] <= mem_byte_in (little-endian); byte_cnt++; mem_addr_out++.
  - When the 4th byte arrives (byte_cnt==3 and mem_valid_in): write {tag, word} into the line and set valid; mem_req_out <= 0; state <= IDLE.
  - The word is not presented directly. The next non-stalled IDLE cycle hits, so miss latency is 4 byte returns + 1 cycle.
  - Outputs during FETCH when not stalled: inst_valid_out <= 0 (ID consumed the previous instruction). When stalled: outputs hold.
- Redirect:
  - branch_taken_in has priority over stall and over everything except rst.
  - Next edge: pc <= branch_target_in; inst_valid_out <= 0; state <= IDLE; mem_req_out <= 0; byte_cnt <= 0.
  - Any mem_valid_in in the same cycle is discarded.
  - Exception: if that same cycle completes the 4th byte, the line is still written (the data is correct for its address), but nothing is presented.
- Width/arithmetic rules:
  - pc+4 and address increments wrap modulo 2^32.
  - PC bits [1:0] are always 0; branch_target_in[1:0] is ignored (forced 0).

Decomposition:
- Defines.v additions: InstAddrBus, InstBus, ICACHE_INDEX_W default, IF state encodings (IF_IDLE, IF_FETCH), RESET_PC.
- One sub-module, icache: valid/tag/data arrays, combinational hit/data lookup, synchronous write port, synchronous valid clear on rst.
- FSM, PC and output registers stay in if_stage.

Test Plan:
- Cold miss at reset: memory at 0..3 = 13 05 a0 00, 1-cycle byte latency -> mem_addr_out steps 0,1,2,3; inst_out=32'h00a00513, pc_out=0, valid=1 one cycle after the last byte; then the fetch of pc=4 starts.
- Warm loop: re-fetch pc 0..12 after the lines are filled -> four consecutive cycles of valid=1, pc_out 0,4,8,12, mem_req_out stays 0.
- Stall: assert stall_in for 3 cycles while valid=1 with pc_out=8 -> pc_out/inst_out/valid unchanged for 3 cycles; pc_out=12 the cycle after release.
- Redirect mid-miss: branch_taken_in, target=0x100, after 2 of 4 bytes -> mem_req_out falls next edge, valid=0, the next request address is 0x100, and the line at the old PC is not written.
- Redirect plus stall plus last byte in the same cycle -> redirect wins: pc=target, valid=0; the old line is written (a later fetch of that PC hits with no memory request).
- Reset mid-fetch: rst after byte 1 -> all outputs zero next edge; a later access to the same PC misses (valid bits cleared).
